// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M shift-add multiplier / restoring divider with pipeline stall
module muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op;
    logic              neg_q, neg_r;
    logic [XLEN-1:0]   op_b;
    logic [2*XLEN-1:0] acc;

    logic              a_sgn, b_sgn, na, nb, div0, ovf;
    logic [XLEN-1:0]   mag_a, mag_b, spec_res, quo, rem, fix_res;
    logic [XLEN:0]     mul_sum, div_diff;
    logic [2*XLEN-1:0] mul_next, div_next, prod;

    assign a_sgn    = func3[2] ? ~func3[0] : (func3[0] ^ func3[1]);
    assign b_sgn    = func3[2] ? ~func3[0] : (func3[1:0] == 2'b01);
    assign na       = a_sgn & src_a[XLEN-1];
    assign nb       = b_sgn & src_b[XLEN-1];
    assign mag_a    = na ? -src_a : src_a;
    assign mag_b    = nb ? -src_b : src_b;
    assign div0     = func3[2] && src_b == '0;
    assign ovf      = func3[2] && !func3[0] && src_a == MIN_NEG && src_b == '1;
    assign spec_res = div0 ? (func3[1] ? src_a : '1) : (func3[1] ? '0 : MIN_NEG);

    // Multiplier lives in acc low half and shifts out as the product shifts in.
    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, op_b} : '0);
    assign mul_next = {mul_sum, acc[XLEN-1:1]};
    // The 33-bit trial keeps the bit shifted out of the remainder.
    assign div_diff = acc[2*XLEN-1:XLEN-1] - {1'b0, op_b};
    assign div_next = div_diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

    assign prod    = neg_q ? -acc : acc;
    assign quo     = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign rem     = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    assign fix_res = op[2] ? (op[1] ? rem : quo)
                           : (op[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);

    assign busy  = state != IDLE;
    assign done  = state == DONE;
    assign stall = (state == IDLE && start && !flush) || state == CALC || state == FIX;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            op     <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            op_b   <= '0;
            acc    <= '0;
            result <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op    <= func3;
                    cnt   <= '0;
                    neg_q <= na ^ nb;
                    neg_r <= na;
                    op_b  <= mag_b;
                    acc   <= {{XLEN{1'b0}}, mag_a};
                    if (div0 || ovf) begin
                        result <= spec_res;
                        state  <= DONE;
                    end else begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc <= op[2] ? div_next : mul_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) state <= FIX;
                end
                FIX: begin
                    result <= fix_res;
                    state  <= DONE;
                end
                DONE: state <= IDLE;
            endcase
        end
    end
endmodule
